scan_code_ctrl: RTL and testbench

//  Sequences the PS/2 scan-code-to-digit converter (combinational: 8-bit code in, 4-bit value out).

---
 rtl/scan_code_ctrl.sv | 125 ++++++++++++
 tb/tb_scan_code_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_code_ctrl.sv
// scan_code_ctrl: tracks the PS/2 byte stream and acts on key releases (F0 xx).
// Each released code goes out on conv_code to an external converter. The
// converter result is sampled in CONVERT. One cycle later, a digit is
// shifted into the history buffer, or a non-digit key raises err_key.
module scan_code_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0,
    parameter int unsigned COUNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    code_ready,
    input  logic [7:0]              scan_code_in,
    output logic [7:0]              conv_code,
    input  logic [3:0]              conv_digit,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    digit_valid,
    output logic                    err_key,
    output logic [COUNT_W-1:0]      key_count
);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        CONVERT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ext;
    logic       w_ext_nxt;
    logic       w_load_code;
    logic       r_pend;
    logic [3:0] r_sample;
    logic       w_commit;
    logic       w_reject;

    // State register and extended-prefix flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ext   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ext   <= w_ext_nxt;
        end
    end

    // Next-state decode: prefixes are absorbed, a released code is latched for conversion
    always_comb begin
        w_state_nxt = r_state;
        w_ext_nxt   = r_ext;
        w_load_code = 1'b0;
        case (r_state)
            IDLE: begin
                if (code_ready) begin
                    if (scan_code_in == EXT_CODE) begin
                        w_ext_nxt = 1'b1;
                    end else if (scan_code_in == BREAK_CODE) begin
                        w_state_nxt = BREAK;
                    end else begin
                        w_ext_nxt = 1'b0;
                    end
                end
            end
            BREAK: begin
                if (code_ready) begin
                    if (scan_code_in == BREAK_CODE) begin
                        w_state_nxt = BREAK;
                    end else if (scan_code_in == EXT_CODE) begin
                        w_ext_nxt = 1'b1;
                    end else if (r_ext) begin
                        w_ext_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load_code = 1'b1;
                        w_state_nxt = CONVERT;
                    end
                end
            end
            CONVERT: begin
                w_ext_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The result sampled in CONVERT is acted on one cycle later. This puts the
    // outputs two edges after the final byte. It also lets the FSM already be
    // back in IDLE for the next byte.
    assign w_commit = r_pend && (r_sample <= 4'd9);
    assign w_reject = r_pend && (r_sample > 4'd9);

    // Datapath: converter drive, result sample, history shift, counter and pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_code   <= '0;
            r_pend      <= 1'b0;
            r_sample    <= '0;
            digits      <= '1;
            digit_valid <= 1'b0;
            err_key     <= 1'b0;
            key_count   <= '0;
        end else begin
            if (w_load_code) begin
                conv_code <= scan_code_in;
            end
            r_pend <= (r_state == CONVERT);
            if (r_state == CONVERT) begin
                r_sample <= conv_digit;
            end
            digit_valid <= w_commit;
            err_key     <= w_reject;
            if (w_commit) begin
                digits    <= {digits[4*NUM_DIGITS-5:0], r_sample};
                key_count <= key_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scan_code_ctrl.sv
// Testbench for scan_code_ctrl. A transaction-level model runs alongside the
// DUT. Every output is compared on each falling edge, and directed
// sequences check final values and pulse counts.
module tb_scan_code_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        code_ready = 1'b0;
    logic [7:0]  scan_code_in = 8'h00;
    logic [7:0]  conv_code;
    logic [3:0]  conv_digit;
    logic [15:0] digits;
    logic        digit_valid;
    logic        err_key;
    logic [7:0]  key_count;

    always #5 clk = ~clk;

    scan_code_ctrl #(
        .NUM_DIGITS(4),
        .BREAK_CODE(8'hF0),
        .EXT_CODE  (8'hE0),
        .COUNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_ready  (code_ready),
        .scan_code_in(scan_code_in),
        .conv_code   (conv_code),
        .conv_digit  (conv_digit),
        .digits      (digits),
        .digit_valid (digit_valid),
        .err_key     (err_key),
        .key_count   (key_count)
    );

    // PS/2 set-2 digit codes, as the external converter would decode them
    function automatic logic [3:0] ps2_to_digit(input logic [7:0] c);
        case (c)
            8'h45: return 4'd0;
            8'h16: return 4'd1;
            8'h1E: return 4'd2;
            8'h26: return 4'd3;
            8'h25: return 4'd4;
            8'h2E: return 4'd5;
            8'h36: return 4'd6;
            8'h3D: return 4'd7;
            8'h3E: return 4'd8;
            8'h46: return 4'd9;
            8'h00: return 4'hF;
            default: return 4'hA;
        endcase
    endfunction

    assign conv_digit = ps2_to_digit(conv_code);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge counter: value equals the number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: outputs expected after the most recent edge
    logic [15:0] m_digits = 16'hFFFF;
    int          m_count  = 0;
    logic [7:0]  m_conv   = 8'h00;
    bit          m_valid  = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_brk    = 1'b0;
    bit          m_ext    = 1'b0;
    bit          m_live   = 1'b0;
    int          pend_edge = -1;
    logic [3:0]  pend_val  = 4'h0;
    int          busy_edge = -1;
    int          n_valid_seen = 0;
    int          n_err_seen   = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check_eq("digits",      32'(digits),      32'(m_digits));
                check_eq("key_count",   32'(key_count),   32'(m_count));
                check_eq("conv_code",   32'(conv_code),   32'(m_conv));
                check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
                check_eq("err_key",     32'(err_key),     32'(m_err));
                if (digit_valid === 1'b1) n_valid_seen++;
                if (err_key === 1'b1) n_err_seen++;
            end
            // Predict the effect of the coming edge (number cyc+1)
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (rst === 1'b0) begin
                m_digits  = 16'hFFFF;
                m_count   = 0;
                m_conv    = 8'h00;
                m_brk     = 1'b0;
                m_ext     = 1'b0;
                pend_edge = -1;
                busy_edge = -1;
                m_live    = 1'b1;
            end else if (m_live) begin
                if (pend_edge == cyc + 1) begin
                    if (pend_val <= 4'd9) begin
                        m_digits = {m_digits[11:0], pend_val};
                        m_count  = (m_count + 1) % 256;
                        m_valid  = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    pend_edge = -1;
                end
                if (busy_edge == cyc + 1) begin
                    busy_edge = -1;   // byte arriving during the conversion cycle is lost
                end else if (code_ready === 1'b1) begin
                    b = scan_code_in;
                    if (!m_brk) begin
                        if (b == 8'hE0) m_ext = 1'b1;
                        else if (b == 8'hF0) m_brk = 1'b1;
                        else m_ext = 1'b0;
                    end else begin
                        if (b == 8'hF0) begin
                            m_brk = 1'b1;
                        end else if (b == 8'hE0) begin
                            m_ext = 1'b1;
                        end else if (m_ext) begin
                            m_ext = 1'b0;
                            m_brk = 1'b0;
                        end else begin
                            m_conv    = b;
                            busy_edge = cyc + 2;
                            pend_edge = cyc + 3;
                            pend_val  = ps2_to_digit(b);
                            m_brk     = 1'b0;
                            m_ext     = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Drivers assume entry at 1 time unit after a rising edge
    task automatic send(input logic [7:0] b, input int gap);
        code_ready   = 1'b1;
        scan_code_in = b;
        @(posedge clk); #1;
        code_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] dig_tab [10];
        int v0;
        int e0;
        int r;
        dig_tab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        // 1: reset held for two clocks
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_digits", 32'(digits), 32'h0000FFFF);
        check_eq("rst_count",  32'(key_count), 32'd0);
        check_eq("rst_conv",   32'(conv_code), 32'h00);
        check_eq("rst_pulses", {30'd0, digit_valid, err_key}, 32'd0);
        rst = 1'b1;
        settle(1);

        // 2: single release of key 1
        v0 = n_valid_seen;
        send(8'h16, 1); send(8'hF0, 1); send(8'h16, 1);
        settle(3);
        check_eq("t2_digits", 32'(digits), 32'h0000FFF1);
        check_eq("t2_count",  32'(key_count), 32'd1);
        check_eq("t2_pulses", 32'(n_valid_seen - v0), 32'd1);

        // 3: keys 1..5 released in turn
        pulse_reset();
        v0 = n_valid_seen;
        for (int k = 1; k <= 5; k++) begin
            send(dig_tab[k], 1); send(8'hF0, 1); send(dig_tab[k], 2);
        end
        settle(3);
        check_eq("t3_digits", 32'(digits), 32'h00002345);
        check_eq("t3_count",  32'(key_count), 32'd5);
        check_eq("t3_pulses", 32'(n_valid_seen - v0), 32'd5);

        // 4: typematic repeats then one release
        pulse_reset();
        send(8'h1E, 1); send(8'h1E, 1); send(8'h1E, 1); send(8'hF0, 1); send(8'h1E, 1);
        settle(3);
        check_eq("t4_digits", 32'(digits), 32'h0000FFF2);
        check_eq("t4_count",  32'(key_count), 32'd1);

        // 5: non-digit key, then an extended key release
        e0 = n_err_seen;
        v0 = n_valid_seen;
        send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
        settle(3);
        check_eq("t5_err", 32'(n_err_seen - e0), 32'd1);
        check_eq("t5_digits", 32'(digits), 32'h0000FFF2);
        send(8'hE0, 1); send(8'h70, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h70, 1);
        settle(3);
        check_eq("t5_ext_pulses", 32'(n_err_seen - e0 + n_valid_seen - v0), 32'd1);
        check_eq("t5_ext_digits", 32'(digits), 32'h0000FFF2);
        check_eq("t5_ext_count",  32'(key_count), 32'd1);

        // 6: reset discards a pending break
        send(8'hF0, 1);
        pulse_reset();
        send(8'h45, 1);
        settle(3);
        check_eq("t6_nocommit", 32'(digits), 32'h0000FFFF);
        send(8'hF0, 1); send(8'h45, 1);
        settle(3);
        check_eq("t6_digits", 32'(digits), 32'h0000FFF0);

        // Randomized stream, including back-to-back bytes and stray resets
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 59) == 0) pulse_reset();
            case (r)
                0, 1, 2: send(8'hF0, $urandom_range(0, 2));
                3:       send(8'hE0, $urandom_range(0, 2));
                4, 5, 6, 7: send(dig_tab[$urandom_range(0, 9)], $urandom_range(0, 2));
                8: begin
                    case ($urandom_range(0, 2))
                        0: send(8'h1C, $urandom_range(0, 2));
                        1: send(8'h70, $urandom_range(0, 2));
                        default: send(8'h00, $urandom_range(0, 2));
                    endcase
                end
                default: send(8'($urandom), $urandom_range(0, 2));
            endcase
        end
        settle(4);

        // Counter wrap: 256 further commits bring the count back to the same value
        v0 = int'(key_count);
        for (int n = 0; n < 256; n++) begin
            send(8'hF0, 0); send(8'h3D, 1);
        end
        settle(3);
        check_eq("wrap_count", 32'(key_count), 32'(v0));
        check_eq("wrap_digits", 32'(digits), 32'h00007777);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
